fancy_timer_param: RTL and testbench
====================================

# fancy_timer_param

Parametrised successor to the team's single-pattern countdown timer, used wherever a serial control line arms a delayed event. The block hunts a serial `data` stream for a configurable start pattern and then shifts in a DELAY_W-bit delay value, MSB first. It then counts `(delay+1)*TICKS_PER_UNIT` cycles while showing the remaining units, and raises `done` until the host acknowledges. It adds an `abort` input and a fill-qualified pattern match on top of its predecessor.

## Interface
- PATTERN_W, 4: start-pattern length in bits (≥2).
- PATTERN, 4'b1101: start pattern; the MSB is the oldest bit received.
- DELAY_W, 4: delay field width in bits (≥1).
- TICKS_PER_UNIT, 1000: cycles per delay unit (≥1).
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  1  serial input, sampled every edge.
- ack  in  1  host acknowledge; honoured only in DONE.
- abort  in  1  cancels any operation in progress and returns the block to SEARCH.
- counting  out  1  high while in COUNT.
- done  out  1  high while in DONE.
- count  out  DELAY_W  remaining delay units while in COUNT; 0 otherwise.

## Operation
- States: SEARCH, LOAD, COUNT, DONE.
- Internal registers:
  - `hist`: PATTERN_W-1 bits, the most recent `data` samples.
  - `fill`: saturating count of bits received since entering SEARCH.
  - `shcnt`: LOAD bit counter.
  - `remain`: DELAY_W-bit remaining-unit count.
  - `tick`: clog2(TICKS_PER_UNIT) bits, minimum 1.
- SEARCH:
  - Each edge: `hist` ← {hist[PATTERN_W-3:0], data}; `fill` increments, saturating at PATTERN_W-1.
  - Match when `fill == PATTERN_W-1` and `{hist, data} == PATTERN`. On a match, go to LOAD with `shcnt`=0.
  - The fill qualification prevents false matches on zero-prefixed patterns after a clear.
  - Overlapping patterns are detected, e.g. 1,1,1,0,1 matches 1101.
- LOAD:
  - Each edge: `remain` ← {remain[DELAY_W-2:0], data}; `shcnt` increments.
  - On the edge that captures bit DELAY_W, go to COUNT with `tick`=0. `remain` then holds the full delay.
- COUNT:
  - Each edge: if `tick == TICKS_PER_UNIT-1`, then `tick`←0 and:
    - if `remain==0`, go to DONE;
    - otherwise `remain` decrements.
  - Otherwise `tick` increments.
  - Total duration is exactly `(delay+1)*TICKS_PER_UNIT` cycles.
- DONE: holds until `ack`=1; then goes to SEARCH.
- Every entry to SEARCH clears `hist` and `fill` to 0.
- `abort`=1 in LOAD, COUNT or DONE forces SEARCH on that edge. `abort` has priority over `ack` and over all transitions.
- `abort` in SEARCH clears `hist` and `fill`; that cycle's `data` is discarded.
- `ack` outside DONE is ignored, with no latching.
- Outputs are Moore, decoded from registered state:
  - `counting` = (state==COUNT).
  - `done` = (state==DONE).
  - `count` = `remain` in COUNT, else 0.
- Reset (synchronous, priority over abort):
  - state SEARCH;
  - `hist`, `fill`, `shcnt`, `remain`, `tick` all 0;
  - `counting`=0, `done`=0, `count`=0.
  - Reset mid-operation discards everything, including any partial pattern.

## Timing
- Pattern completion: the edge sampling the last pattern bit enters LOAD.
- Delay capture: the next DELAY_W edges capture the delay bits.
- COUNT entry: `counting` rises the cycle after the last delay bit is sampled.
- `count` output:
  - Equals the loaded delay during the first TICKS_PER_UNIT cycles of COUNT.
  - Steps down by 1 every TICKS_PER_UNIT cycles.
  - Shows 0 for the final unit.
- COUNT exit: `counting` falls and `done` rises on the same edge, (delay+1)*TICKS_PER_UNIT cycles after COUNT entry.
- Acknowledge: `done` falls on the edge after `ack` is sampled high. The next pattern bit is the first `data` sampled in SEARCH after that edge.
- Data sampling in LOAD, COUNT and DONE: bits in COUNT and DONE are ignored and never contribute to pattern history.
- Abort and reset: outputs go inactive one edge after `abort` or `reset` is sampled high.

## Test plan
- Basic timing:
  - Stimulus: TICKS_PER_UNIT=4; data 1,1,0,1 then 0,1,0,1.
  - Response: `counting` high for exactly 24 cycles; `count` shows 5 for 4 cycles, then 4, … then 0; `done` rises as `counting` falls.
  - Ack timing: `done` stays high for 10 idle cycles; `ack` pulse → `done` low next cycle.
- Overlap and boundaries:
  - Overlap: data 1,1,1,0,1 matches.
  - Fill qualification: with PATTERN=4'b0001, the first match needs 4 received bits after reset.
  - Delay 0: COUNT lasts exactly TICKS_PER_UNIT cycles with `count`=0.
  - Delay 15: COUNT lasts 16*TICKS_PER_UNIT cycles.
- Ack outside DONE:
  - Stimulus: `ack` held high throughout SEARCH, LOAD and COUNT.
  - Response: no effect on any state.
  - Then: `done` asserts, and the still-high `ack` returns the block to SEARCH one cycle later.
- Abort:
  - Abort in LOAD, mid-COUNT and in DONE each → SEARCH next edge, outputs 0.
  - After abort, bits 1,0,1 alone do not match; a full 1101 is needed.
  - `abort` and `ack` together in DONE → SEARCH.
- Reset mid-COUNT:
  - Response: all outputs 0 next cycle; no stale history.
  - Reset held high with `data`=1,1,0,1 produces no LOAD.
- Parameter variant:
  - Stimulus: PATTERN_W=6, PATTERN=6'b101100, DELAY_W=3, TICKS_PER_UNIT=1, delay 3'b111.
  - Response: `counting` for 8 cycles; `count` 7…0, one cycle each.

Source files
------------

// File: rtl/fancy_timer_param.sv
// fancy_timer_param
//   Hunts a serial stream for a start pattern, shifts in a DELAY_W-bit delay
//   (MSB first), then counts (delay+1)*TICKS_PER_UNIT cycles while showing the
//   remaining units, and finally holds `done` until the host acknowledges.
//   `abort` returns the block to SEARCH from any state.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high reset
//   data      in   serial input, sampled every edge
//   ack       in   host acknowledge, only honoured in DONE
//   abort     in   cancel any operation, return to SEARCH
//   counting  out  high while counting down
//   done      out  high while waiting for ack
//   count     out  remaining delay units while counting, else 0
module fancy_timer_param #(
  parameter int                   PATTERN_W      = 4,
  parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1101,
  parameter int                   DELAY_W        = 4,
  parameter int                   TICKS_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] count
);

  localparam int FILL_W = $clog2(PATTERN_W);
  localparam int SH_W   = $clog2(DELAY_W + 1);
  localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PATTERN_W - 1);
  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(DELAY_W - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state_q,  state_d;
  logic [PATTERN_W-2:0] hist_q,   hist_d;
  logic [FILL_W-1:0]    fill_q,   fill_d;
  logic [SH_W-1:0]      shcnt_q,  shcnt_d;
  logic [DELAY_W-1:0]   remain_q, remain_d;
  logic [TICK_W-1:0]    tick_q,   tick_d;

  // Shifted versions built structurally so 1-bit-wide corner cases
  // (PATTERN_W==2, DELAY_W==1) never elaborate a reversed slice.
  logic [PATTERN_W-2:0] hist_shift;
  logic [DELAY_W-1:0]   remain_shift;
  logic [PATTERN_W-1:0] window;

  generate
    if (PATTERN_W == 2) begin : g_hist1
      assign hist_shift = data;
    end else begin : g_histn
      assign hist_shift = {hist_q[PATTERN_W-3:0], data};
    end
    if (DELAY_W == 1) begin : g_rem1
      assign remain_shift = data;
    end else begin : g_remn
      assign remain_shift = {remain_q[DELAY_W-2:0], data};
    end
  endgenerate

  // Oldest history bit lands in the pattern MSB.
  assign window = {hist_q, data};

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    shcnt_d  = shcnt_q;
    remain_d = remain_q;
    tick_d   = tick_q;

    if (abort) begin
      // Abort wins over ack and every transition; in SEARCH it also
      // throws away this cycle's data bit.
      state_d = S_SEARCH;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_SEARCH: begin
          hist_d = hist_shift;
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
          // Fill qualification: history must be made of real samples,
          // otherwise a zero-prefixed pattern would match the cleared regs.
          if (fill_q == FILL_MAX && window == PATTERN) begin
            state_d = S_LOAD;
            shcnt_d = '0;
          end
        end
        S_LOAD: begin
          remain_d = remain_shift;
          shcnt_d  = shcnt_q + 1'b1;
          if (shcnt_q == SH_LAST) begin
            state_d = S_COUNT;
            tick_d  = '0;
          end
        end
        S_COUNT: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (remain_q == '0) state_d = S_DONE;
            else                remain_d = remain_q - 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DONE: begin
          if (ack) state_d = S_SEARCH;
        end
        default: state_d = S_SEARCH;
      endcase
    end

    // Every return to SEARCH starts pattern hunting from scratch.
    if (state_q != S_SEARCH && state_d == S_SEARCH) begin
      hist_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_SEARCH;
      hist_q   <= '0;
      fill_q   <= '0;
      shcnt_q  <= '0;
      remain_q <= '0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      shcnt_q  <= shcnt_d;
      remain_q <= remain_d;
      tick_q   <= tick_d;
    end
  end

  assign counting = (state_q == S_COUNT);
  assign done     = (state_q == S_DONE);
  assign count    = counting ? remain_q : '0;

endmodule

// File: tb/tb_fancy_timer_param.sv
// Drives one shared stimulus stream into three parameter variants and checks
// every cycle against a phase/cycles-left reference model.
module tb_fancy_timer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, data, ack, abort;
  logic [2:0] cnt_o, dn_o;
  logic [3:0] ca, cb;
  logic [2:0] cc;

  fancy_timer_param #(.PATTERN_W(4), .PATTERN(4'b1101), .DELAY_W(4), .TICKS_PER_UNIT(4)) u_a (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .abort(abort),
    .counting(cnt_o[0]), .done(dn_o[0]), .count(ca));
  fancy_timer_param #(.PATTERN_W(4), .PATTERN(4'b0001), .DELAY_W(4), .TICKS_PER_UNIT(1)) u_b (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .abort(abort),
    .counting(cnt_o[1]), .done(dn_o[1]), .count(cb));
  fancy_timer_param #(.PATTERN_W(6), .PATTERN(6'b101100), .DELAY_W(3), .TICKS_PER_UNIT(1)) u_c (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .abort(abort),
    .counting(cnt_o[2]), .done(dn_o[2]), .count(cc));

  // Model parameters per variant
  int    PW[3]  = '{4, 4, 6};
  int    PAT[3] = '{13, 1, 44};
  int    DW[3]  = '{4, 4, 3};
  int    TK[3]  = '{4, 1, 1};
  string nm[3]  = '{"a", "b", "c"};

  // Model state: phase 0 search, 1 load, 2 count, 3 done
  int ph[3], nseen[3], hist[3], dly[3], nb[3], left[3];
  int cyc[3];          // cycles each variant has been seen counting
  int nchk = 0, errs = 0;

  task automatic chk(string tag, int got, int exp);
    nchk++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void to_search(int k);
    ph[k] = 0; nseen[k] = 0; hist[k] = 0;
  endfunction

  task automatic step(bit d, bit a, bit ab, bit r);
    int got_cnt;
    data = d; ack = a; abort = ab; reset = r;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        to_search(k);
      end else if (ab) begin
        to_search(k);
      end else begin
        case (ph[k])
          0: begin
            hist[k] = ((hist[k] << 1) | int'(d)) & ((1 << PW[k]) - 1);
            nseen[k]++;
            if (nseen[k] >= PW[k] && hist[k] == PAT[k]) begin
              ph[k] = 1; dly[k] = 0; nb[k] = 0;
            end
          end
          1: begin
            dly[k] = dly[k] * 2 + int'(d);
            nb[k]++;
            if (nb[k] == DW[k]) begin
              ph[k] = 2; left[k] = (dly[k] + 1) * TK[k];
            end
          end
          2: begin
            left[k]--;
            if (left[k] == 0) ph[k] = 3;
          end
          default: if (a) to_search(k);
        endcase
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      got_cnt = (k == 0) ? int'(ca) : (k == 1) ? int'(cb) : int'(cc);
      chk({nm[k], "_counting"}, int'(cnt_o[k]), int'(ph[k] == 2));
      chk({nm[k], "_done"}, int'(dn_o[k]), int'(ph[k] == 3));
      chk({nm[k], "_count"}, got_cnt, (ph[k] == 2) ? (left[k] - 1) / TK[k] : 0);
      if (cnt_o[k] === 1'b1) cyc[k]++;
    end
  endtask

  task automatic send(logic [15:0] v, int n, bit a = 1'b0);
    for (int i = n - 1; i >= 0; i--) step(v[i], a, 1'b0, 1'b0);
  endtask

  task automatic idle(int n, bit a = 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, a, 1'b0, 1'b0);
  endtask

  task automatic clr_cyc();
    for (int k = 0; k < 3; k++) cyc[k] = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      to_search(k); dly[k] = 0; nb[k] = 0; left[k] = 0; cyc[k] = 0;
    end
    data = 0; ack = 0; abort = 0; reset = 1;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Basic timing: pattern, delay 5 -> 24 counting cycles, done held 10 idle cycles
    clr_cyc();
    send(16'b1101, 4);
    send(16'b0101, 4);
    idle(34);
    chk("basic_len", cyc[0], 24);
    chk("basic_done_held", int'(dn_o[0]), 1);
    step(0, 1, 0, 0);
    chk("basic_ack_drop", int'(dn_o[0]), 0);
    idle(2);

    // Overlap 1,1,1,0,1 plus delay 0 -> one unit of count 0
    clr_cyc();
    send(16'b11101, 5);
    send(16'b0000, 4);
    idle(6);
    chk("delay0_len", cyc[0], 4);
    step(0, 1, 0, 0);
    idle(2);

    // Delay 15 -> 64 counting cycles
    clr_cyc();
    send(16'b1101, 4);
    send(16'b1111, 4);
    idle(67);
    chk("delay15_len", cyc[0], 64);
    step(0, 1, 0, 0);
    idle(2);

    // Ack held high throughout: no effect until DONE, then leaves next cycle
    clr_cyc();
    send(16'b1101_0010, 8, 1'b1);
    idle(14, 1'b1);
    chk("ackhigh_len", cyc[0], 12);
    idle(2);

    // Abort in LOAD, then 1,0,1 alone must not match
    clr_cyc();
    send(16'b1101, 4);
    send(16'b10, 2);
    step(0, 0, 1, 0);
    send(16'b101, 3);
    idle(8);
    // Abort in SEARCH after a 1 discards that history
    send(16'b1, 1);
    step(1, 0, 1, 0);
    send(16'b101, 3);
    idle(8);
    chk("abort_nomatch", cyc[0], 0);
    // Abort mid-COUNT
    send(16'b1101_0011, 8);
    idle(5);
    step(0, 0, 1, 0);
    idle(2);
    // Abort and ack together in DONE
    send(16'b1101_0000, 8);
    idle(5);
    step(0, 1, 1, 0);
    idle(2);
    // Abort alone in DONE
    send(16'b1101_0000, 8);
    idle(5);
    step(0, 0, 1, 0);
    idle(2);

    // Reset mid-COUNT, then reset held while 1101 arrives
    send(16'b1101_0111, 8);
    idle(6);
    step(0, 0, 0, 1);
    clr_cyc();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    idle(10);
    chk("reset_held_nomatch", cyc[0], 0);

    // Parameter variant: 101100 then delay 7 on the 6-bit/TICKS=1 instance
    step(0, 0, 0, 1);
    clr_cyc();
    send(16'b101100, 6);
    send(16'b111, 3);
    idle(10);
    chk("variant_len", cyc[2], 8);
    idle(2, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 255) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, errs);
    $finish;
  end

endmodule
